multi_clk_gen: RTL and testbench
================================

Name: multi_clk_gen

Overview:
- N-channel fractional clock/tick generator built from phase accumulators (DDS style). It is the parametrised successor to the fixed UART/VGA divider pair.
- It drives any number of derived clocks from clk_board, with sub-integer frequency resolution.
- Each channel's frequency can be reprogrammed at run time through a valid/ready config port. A new value takes effect glitch-free at that channel's next phase wrap.

Parameters:
- CHANNELS, 2: number of output channels (>=1).
- ACC_WIDTH, 32: phase accumulator width; f_out = f_clk_board * inc / 2^ACC_WIDTH.
- DEFAULT_INC, {32'd2162516034, 32'd13194140}: packed CHANNELS*ACC_WIDTH reset increments, channel 0 in the LSBs. Defaults give ch0 = 153600 Hz (9600*16) and ch1 = 25175000 Hz from 50 MHz.
- CHAN_W, (CHANNELS>1 ? $clog2(CHANNELS) : 1): width of the channel select.

Ports:
- clk_board  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  global run; 0 freezes all accumulators.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept; a transfer occurs when cfg_valid & cfg_ready.
- cfg_chan  input  CHAN_W  target channel.
- cfg_inc  input  ACC_WIDTH  new increment.
- cfg_err  output  1  one-cycle pulse when an accepted request targets cfg_chan >= CHANNELS.
- clk_out  output  CHANNELS  per-channel square clock (accumulator MSB, registered).
- tick  output  CHANNELS  per-channel one-cycle strobe on accumulator carry.

Behaviour:
- Reset (reset=0, asynchronous): all accumulators = 0; inc[c] = DEFAULT_INC[c]; shadow registers = 0; pending = 0; clk_out = 0; tick = 0; cfg_err = 0.
- Per channel per cycle with enable=1:
  - sum = {1'b0, acc} + inc, computed ACC_WIDTH+1 bits wide.
  - acc <= sum[ACC_WIDTH-1:0].
  - tick <= sum[ACC_WIDTH] (carry).
  - clk_out <= sum[ACC_WIDTH-1].
  - Latency: one register stage, so a carry produced on edge k is visible on tick after edge k.
- enable=0: acc, clk_out and inc hold; tick <= 0. Phase is continuous on resume. The config port keeps working, and pending updates are applied per the rules below.
- inc=0: the channel is stopped. acc holds, no ticks, clk_out holds.
- Config handshake:
  - cfg_ready = ~pending[cfg_chan] for in-range cfg_chan; cfg_ready = 1 when out of range.
  - On accept with a valid channel: shadow[c] <= cfg_inc; pending[c] <= 1.
  - On accept with an out-of-range channel: no state change; cfg_err <= 1 for one cycle.
- Apply rules:
  - When pending[c] and the channel carries (sum carry=1 with enable=1): inc[c] <= shadow[c] and pending[c] <= 0 on that edge. The addition on that edge uses the old inc.
  - If inc[c]==0 or enable=0 while pending[c], the new value is applied on the next edge (no waiting for a wrap).
- Simultaneous events: a channel cannot be both accepted and applied in the same cycle (ready is low while pending). Different channels operate fully independently in the same cycle.
- Jitter: when 2^ACC_WIDTH is not a multiple of inc, tick spacing alternates between floor and ceil of 2^ACC_WIDTH/inc cycles. The long-run average is exact.
- Reset asserted mid-operation discards pending configs and restores the defaults.

Optional Feature:
- Macro: CLK_GEN_PHASE_ALIGN_EN.
- Defined: adds an input port phase_sync (1 bit, active-high).
  - On an edge with phase_sync=1, all accumulators are cleared to 0 and all pending increments are applied immediately.
  - tick <= 0 and clk_out <= 0 on that edge.
  - phase_sync has priority over enable and over carry-apply.
  - This aligns all channels so the first post-sync ticks are phase-coherent.
- Undefined: the port is absent and there is no alignment logic. Behaviour is otherwise identical.

Test Plan:
All scenarios use ACC_WIDTH=8, CHANNELS=3, DEFAULT_INC={8'd0, 8'd128, 8'd64}.
1. Release reset, enable=1 -> tick[0] high every 4th cycle (first at the 4th edge). tick[1] every 2nd cycle. clk_out[1] toggles each cycle. Channel 2 shows no ticks and clk_out[2]=0.
2. Config ch2 inc=96 (ch2 currently 0, so the update applies on the next edge) -> exactly 3 ticks per 8 cycles, spacing pattern 3,3,2 repeating.
3. Config ch0 inc=32 two cycles after a tick[0] -> cfg_ready (for cfg_chan=0) low until the next tick[0]. That period stays 4; subsequent tick[0] period is 8.
4. Drop enable for 5 cycles mid-period -> no ticks, acc and clk_out frozen. After re-enable, the remaining cycles to the next tick equal the value before the freeze.
5. cfg_chan=3, cfg_valid=1 -> accepted immediately; cfg_err pulses exactly 1 cycle; all incs unchanged.
6. Assert reset asynchronously mid-run with ch0 pending -> clk_out, tick and cfg_err go 0 without a clock edge. After release, ch0 period is 4 again (default restored) and pending is cleared. With CLK_GEN_PHASE_ALIGN_EN defined, a phase_sync pulse makes all channels' accumulators 0 and the next tick[0] follows exactly 4 cycles later.

Source files
------------

// File: rtl/multi_clk_gen.sv
// N-channel DDS clock/tick generator: per-channel phase accumulators with run-time increments
// that take effect at phase wrap. Define CLK_GEN_PHASE_ALIGN_EN to add the phase_sync input.
module multi_clk_gen #(
    parameter int unsigned                   CHANNELS    = 2,
    parameter int unsigned                   ACC_WIDTH   = 32,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] DEFAULT_INC = {32'd2162516034, 32'd13194140},
    parameter int unsigned                   CHAN_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk_board,
    input  logic                 reset,
    input  logic                 enable,
`ifdef CLK_GEN_PHASE_ALIGN_EN
    input  logic                 phase_sync,
`endif
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CHAN_W-1:0]    cfg_chan,
    input  logic [ACC_WIDTH-1:0] cfg_inc,
    output logic                 cfg_err,
    output logic [CHANNELS-1:0]  clk_out,
    output logic [CHANNELS-1:0]  tick
);

    logic [CHANNELS-1:0] pending;
    logic                chan_ok;
    logic                cfg_fire;
    logic                sync;
    logic                cfg_err_q;

`ifdef CLK_GEN_PHASE_ALIGN_EN
    assign sync = phase_sync;
`else
    assign sync = 1'b0;
`endif

    assign chan_ok = (32'(cfg_chan) < CHANNELS);

    // Out-of-range requests are always accepted so they can be flagged and dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (cfg_chan == CHAN_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
    end

    assign cfg_fire = cfg_valid & cfg_ready;

    always_ff @(posedge clk_board or negedge reset) begin
        if (!reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_fire & ~chan_ok;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [ACC_WIDTH-1:0] acc_q, acc_d;
        logic [ACC_WIDTH-1:0] inc_q, inc_d;
        logic [ACC_WIDTH-1:0] shadow_q, shadow_d;
        logic                 pending_q, pending_d;
        logic                 clk_q, clk_d;
        logic                 tick_q, tick_d;
        logic [ACC_WIDTH:0]   sum;
        logic                 carry;
        logic                 accept;

        assign sum    = {1'b0, acc_q} + {1'b0, inc_q};
        assign carry  = enable & sum[ACC_WIDTH];
        assign accept = cfg_fire & (cfg_chan == CHAN_W'(c));

        always_comb begin
            acc_d     = acc_q;
            inc_d     = inc_q;
            shadow_d  = shadow_q;
            pending_d = pending_q;
            clk_d     = clk_q;
            tick_d    = 1'b0;
            if (sync) begin
                acc_d = '0;
                clk_d = 1'b0;
                if (pending_q) begin
                    inc_d     = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                if (enable) begin
                    acc_d  = sum[ACC_WIDTH-1:0];
                    clk_d  = sum[ACC_WIDTH-1];
                    tick_d = sum[ACC_WIDTH];
                end
                // A stopped or frozen channel never wraps, so swap without waiting.
                if (pending_q && (carry || (inc_q == '0) || !enable)) begin
                    inc_d     = shadow_q;
                    pending_d = 1'b0;
                end
            end
            if (accept) begin
                shadow_d  = cfg_inc;
                pending_d = 1'b1;
            end
        end

        always_ff @(posedge clk_board or negedge reset) begin
            if (!reset) begin
                acc_q     <= '0;
                inc_q     <= DEFAULT_INC[c*ACC_WIDTH +: ACC_WIDTH];
                shadow_q  <= '0;
                pending_q <= 1'b0;
                clk_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                acc_q     <= acc_d;
                inc_q     <= inc_d;
                shadow_q  <= shadow_d;
                pending_q <= pending_d;
                clk_q     <= clk_d;
                tick_q    <= tick_d;
            end
        end

        assign pending[c] = pending_q;
        assign clk_out[c] = clk_q;
        assign tick[c]    = tick_q;
    end

endmodule

// File: tb/tb_multi_clk_gen.sv
// Self-checking bench for multi_clk_gen: directed scenarios plus randomized traffic checked
// against an integer phase model of each channel.
module tb_multi_clk_gen;

    localparam int NCH = 3;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_inc;
    logic       cfg_err;
    logic [2:0] clk_out;
    logic [2:0] tick;
    bit         psync;

    multi_clk_gen #(
        .CHANNELS   (3),
        .ACC_WIDTH  (8),
        .DEFAULT_INC({8'd0, 8'd128, 8'd64})
    ) dut (
        .clk_board (clk),
        .reset     (reset),
        .enable    (enable),
`ifdef CLK_GEN_PHASE_ALIGN_EN
        .phase_sync(psync),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: phase as an integer modulo 256.
    int         m_acc[NCH];
    int         m_inc[NCH];
    int         m_sh[NCH];
    bit         m_pend[NCH];
    logic [2:0] e_tick;
    logic [2:0] e_clk;
    logic       e_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_acc  = '{0, 0, 0};
        m_inc  = '{64, 128, 0};
        m_sh   = '{0, 0, 0};
        m_pend = '{0, 0, 0};
        e_tick = '0;
        e_clk  = '0;
        e_err  = 1'b0;
    endfunction

    function automatic void model_edge(input bit en, input bit fire, input int ch, input int cinc,
                                       input bit sy);
        for (int c = 0; c < NCH; c++) begin
            int s;
            bit wrapped;
            s = m_acc[c] + m_inc[c];
            wrapped = en && (s >= 256);
            e_tick[c] = 1'b0;
            if (sy) begin
                m_acc[c] = 0;
                e_clk[c] = 1'b0;
                if (m_pend[c]) begin
                    m_inc[c]  = m_sh[c];
                    m_pend[c] = 1'b0;
                end
            end else begin
                if (en) begin
                    e_tick[c] = (s >= 256);
                    m_acc[c]  = s % 256;
                    e_clk[c]  = (m_acc[c] >= 128);
                end
                if (m_pend[c] && (wrapped || m_inc[c] == 0 || !en)) begin
                    m_inc[c]  = m_sh[c];
                    m_pend[c] = 1'b0;
                end
            end
            if (fire && ch == c) begin
                m_sh[c]   = cinc;
                m_pend[c] = 1'b1;
            end
        end
        e_err = fire && (ch >= NCH);
    endfunction

    // One clock: check ready before the edge, advance model, check outputs after it.
    task automatic cycle();
        bit rdy;
        bit fire;
        int ch;
        ch   = int'(cfg_chan);
        rdy  = (ch >= NCH) ? 1'b1 : !m_pend[ch];
        chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
        fire = cfg_valid && rdy;
        @(posedge clk);
        #1;
        model_edge(enable, fire, ch, int'(cfg_inc), psync);
        chk("tick", 32'(tick), 32'(e_tick));
        chk("clk_out", 32'(clk_out), 32'(e_clk));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
    endtask

    task automatic wait_tick(input int ch, input int limit, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick[ch] && n < limit);
    endtask

    initial begin
        int n;
        int cnt;
        logic [2:0] snap;

        reset     = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_inc   = '0;
        psync     = 1'b0;
        model_reset();
        #2;
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        #5;
        reset  = 1'b1;
        enable = 1'b1;

        // Default rates: ch0 every 4th edge, ch1 every 2nd, ch2 stopped.
        for (int i = 0; i < 3; i++) cycle();
        chk("s1_no_early_tick0", 32'(tick[0]), 0);
        cycle();
        chk("s1_tick0_edge4", 32'(tick[0]), 1);
        for (int i = 0; i < 4; i++) cycle();
        chk("s1_ch2_clk_low", 32'(clk_out[2]), 0);

        // ch2 from stopped to inc=96: applies on the next edge, 3 ticks per 8 cycles.
        cfg_valid = 1'b1;
        cfg_chan  = 2'd2;
        cfg_inc   = 8'd96;
        cycle();
        cfg_valid = 1'b0;
        cycle();
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            cnt += int'(tick[2]);
        end
        chk("s2_ticks_per_16", 32'(cnt), 6);

        // ch0 reprogram two cycles after a tick: current period stays 4, then 8.
        cfg_chan = 2'd0;
        wait_tick(0, 8, n);
        cycle();
        cfg_valid = 1'b1;
        cfg_inc   = 8'd32;
        cycle();
        cfg_valid = 1'b0;
        chk("s3_ready_low", 32'(cfg_ready), 0);
        wait_tick(0, 8, n);
        chk("s3_old_period", 32'(n), 2);
        chk("s3_ready_back", 32'(cfg_ready), 1);
        wait_tick(0, 16, n);
        chk("s3_new_period", 32'(n), 8);

        // Freeze 5 cycles mid-period; remaining distance to the tick is preserved.
        for (int i = 0; i < 3; i++) cycle();
        enable = 1'b0;
        snap   = clk_out;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("s4_frozen_clk", 32'(clk_out), 32'(snap));
            chk("s4_no_tick", 32'(tick), 0);
        end
        enable = 1'b1;
        wait_tick(0, 16, n);
        chk("s4_remaining", 32'(n), 5);

        // Out-of-range channel: accepted at once, one-cycle error pulse.
        cfg_valid = 1'b1;
        cfg_chan  = 2'd3;
        cfg_inc   = 8'd7;
        chk("s5_ready", 32'(cfg_ready), 1);
        cycle();
        cfg_valid = 1'b0;
        chk("s5_err_pulse", 32'(cfg_err), 1);
        cycle();
        chk("s5_err_clear", 32'(cfg_err), 0);
        for (int i = 0; i < 8; i++) cycle();

        // Async reset with ch0 pending and cfg_err high.
        cfg_valid = 1'b1;
        cfg_chan  = 2'd0;
        cfg_inc   = 8'd200;
        cycle();
        cfg_chan = 2'd3;
        cycle();
        cfg_valid = 1'b0;
        cfg_chan  = 2'd0;
        #2;
        reset = 1'b0;
        #1;
        chk("s6_clk_out", 32'(clk_out), 0);
        chk("s6_tick", 32'(tick), 0);
        chk("s6_cfg_err", 32'(cfg_err), 0);
        chk("s6_pending_clr", 32'(cfg_ready), 1);
        model_reset();
        #2;
        reset = 1'b1;
        wait_tick(0, 8, n);
        chk("s6_first_tick", 32'(n), 4);
        wait_tick(0, 8, n);
        chk("s6_default_period", 32'(n), 4);

`ifdef CLK_GEN_PHASE_ALIGN_EN
        cycle();
        psync = 1'b1;
        cycle();
        psync = 1'b0;
        chk("sync_tick", 32'(tick), 0);
        chk("sync_clk", 32'(clk_out), 0);
        wait_tick(0, 8, n);
        chk("sync_period", 32'(n), 4);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_chan  = 2'($urandom_range(0, 3));
            cfg_inc   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
`ifdef CLK_GEN_PHASE_ALIGN_EN
            psync     = ($urandom_range(0, 31) == 0);
`endif
            cycle();
        end
        cfg_valid = 1'b0;
        psync     = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
